// File: rtl/validador.sv
// Battleship placement validator: expands a piece request into board cells, checks board
// limits and overlap against the player's piece RAM, then writes the encoded piece.
// Define ADJACENCY_CHECK_EN to also reject new cells touching stored cells (8-neighbourhood).
module validador #(
    parameter int BOARD_SIZE = 10,
    parameter int MAX_PIECES = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [2:0]  tipo,
    input  logic        direcao,
    input  logic [2:0]  orientacao,
    input  logic [3:0]  x1,
    input  logic [3:0]  y1,
    input  logic        jogador,
    input  logic [63:0] vetor_leitura,
    output logic        ready,
    output logic        conflitoMemoria_out,
    output logic        conflitoBorda_out,
    output logic        conflito,
    output logic        wrep1,
    output logic        wrep2,
    output logic [63:0] vetor,
    output logic [4:0]  read_addr,
    output logic [4:0]  write_addr
);

    typedef enum logic [2:0] {IDLE, EXPAND, SCAN, WRITE, DONE} state_t;
    state_t state, state_nx;

    logic [2:0]  tipo_q, ori_q;
    logic        dir_q, jog_q;
    logic [3:0]  x_q, y_q;
    logic [3:0]  cnt [2];
    logic [4:0]  raddr_q, chk_q;
    logic        borda_q, mem_q;
    logic [63:0] vetor_q;

    logic [3:0]  cur_cnt;
    logic [4:0]  last_addr;
    logic        full;
    logic [4:0]  base_x, base_y;
    logic [4:0]  cx [5];
    logic [4:0]  cy [5];
    logic [4:0]  used;
    logic        bad_tipo, off, hit;
    logic [2:0]  n_line;
    logic [63:0] word;
    logic        unused_word;

    assign cur_cnt     = cnt[jog_q];
    assign last_addr   = {1'b0, cur_cnt} - 5'd1;
    assign full        = (cur_cnt == 4'(MAX_PIECES));
    assign base_x      = {1'b0, x_q};
    assign base_y      = {1'b0, y_q};
    assign unused_word = ^vetor_leitura[62:45];

    function automatic logic cell_match(input logic [3:0] sx, input logic [3:0] sy,
                                        input logic [3:0] nx, input logic [3:0] ny);
`ifdef ADJACENCY_CHECK_EN
        logic [4:0] dx, dy;
        dx = {1'b0, sx} - {1'b0, nx};
        dy = {1'b0, sy} - {1'b0, ny};
        return (dx == 5'd0 || dx == 5'd1 || dx == 5'h1f) &&
               (dy == 5'd0 || dy == 5'd1 || dy == 5'h1f);
`else
        return (sx == nx) && (sy == ny);
`endif
    endfunction

    // Cell expansion in 5-bit two's complement so x-1 / y-1 underflow shows as negative.
    always_comb begin
        used     = '0;
        bad_tipo = 1'b0;
        n_line   = 3'd5 - tipo_q;
        for (int unsigned i = 0; i < 5; i++) begin
            cx[i] = base_x;
            cy[i] = base_y;
        end
        case (tipo_q)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                for (int unsigned i = 0; i < 5; i++) begin
                    if (3'(i) < n_line) begin
                        used[i] = 1'b1;
                        if (dir_q) cy[i] = base_y + 5'(i);
                        else       cx[i] = base_x + 5'(i);
                    end
                end
            end
            3'd4: begin
                used = 5'b00111;
                case (ori_q[1:0])
                    2'd0: begin
                        cx[1] = base_x + 5'd1; cy[1] = base_y + 5'd1;
                        cx[2] = base_x + 5'd2;
                    end
                    2'd1: begin
                        cx[1] = base_x + 5'd1; cy[1] = base_y - 5'd1;
                        cx[2] = base_x + 5'd2;
                    end
                    2'd2: begin
                        cx[1] = base_x + 5'd1; cy[1] = base_y + 5'd1;
                        cy[2] = base_y + 5'd2;
                    end
                    default: begin
                        cx[1] = base_x - 5'd1; cy[1] = base_y + 5'd1;
                        cy[2] = base_y + 5'd2;
                    end
                endcase
            end
            default: bad_tipo = 1'b1;
        endcase
    end

    always_comb begin
        off  = bad_tipo;
        word = '0;
        word[63]    = 1'b1;
        word[62:60] = tipo_q;
        word[59:57] = ori_q;
        word[56]    = dir_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (used[i]) begin
                word[9*i +: 9] = {1'b1, cx[i][3:0], cy[i][3:0]};
                if (cx[i][4] || cx[i] >= 5'(BOARD_SIZE) || cy[i][4] || cy[i] >= 5'(BOARD_SIZE))
                    off = 1'b1;
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int unsigned j = 0; j < 5; j++) begin
            for (int unsigned k = 0; k < 5; k++) begin
                if (vetor_leitura[63] && vetor_leitura[9*j+8] && used[k] &&
                    cell_match(vetor_leitura[9*j+4 +: 4], vetor_leitura[9*j +: 4],
                               cx[k][3:0], cy[k][3:0]))
                    hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx            = state;
        ready               = 1'b0;
        wrep1               = 1'b0;
        wrep2               = 1'b0;
        write_addr          = '0;
        read_addr           = raddr_q;
        vetor               = vetor_q;
        conflitoBorda_out   = borda_q;
        conflitoMemoria_out = mem_q;
        conflito            = borda_q | mem_q;
        case (state)
            IDLE:   if (enable) state_nx = EXPAND;
            EXPAND: begin
                if (off || full)        state_nx = DONE;
                else if (cur_cnt == '0) state_nx = WRITE;
                else                    state_nx = SCAN;
            end
            SCAN: begin
                if (hit)                     state_nx = DONE;
                else if (chk_q == last_addr) state_nx = WRITE;
            end
            WRITE: begin
                wrep1      = ~jog_q;
                wrep2      = jog_q;
                write_addr = {1'b0, cur_cnt};
                state_nx   = DONE;
            end
            DONE: begin
                ready = 1'b1;
                if (!enable) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read address runs one entry ahead of the compare index to cover RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tipo_q  <= '0;
            ori_q   <= '0;
            dir_q   <= 1'b0;
            jog_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            cnt[0]  <= '0;
            cnt[1]  <= '0;
            raddr_q <= '0;
            chk_q   <= '0;
            borda_q <= 1'b0;
            mem_q   <= 1'b0;
            vetor_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    raddr_q <= '0;
                    chk_q   <= '0;
                    if (enable) begin
                        tipo_q <= tipo;
                        ori_q  <= orientacao;
                        dir_q  <= direcao;
                        jog_q  <= jogador;
                        x_q    <= x1;
                        y_q    <= y1;
                    end
                end
                EXPAND: begin
                    vetor_q <= word;
                    borda_q <= off;
                    mem_q   <= ~off & full;
                    if (state_nx == SCAN && raddr_q < last_addr) raddr_q <= raddr_q + 5'd1;
                end
                SCAN: begin
                    chk_q <= chk_q + 5'd1;
                    mem_q <= hit;
                    if (raddr_q < last_addr) raddr_q <= raddr_q + 5'd1;
                end
                WRITE: cnt[jog_q] <= cnt[jog_q] + 4'd1;
                DONE: begin
                    if (!enable) begin
                        borda_q <= 1'b0;
                        mem_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_validador.sv
// Scoreboard bench for validador: a cell-level reference model predicts each request's
// outcome; a separate monitor compares when ready rises and checks write strobes.
module tb_validador;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  tipo = '0;
    logic        direcao = 1'b0;
    logic [2:0]  orientacao = '0;
    logic [3:0]  x1 = '0;
    logic [3:0]  y1 = '0;
    logic        jogador = 1'b0;
    logic [63:0] vetor_leitura = '0;
    logic        ready, conflitoMemoria_out, conflitoBorda_out, conflito, wrep1, wrep2;
    logic [63:0] vetor;
    logic [4:0]  read_addr, write_addr;

    always #5 clk = ~clk;

    validador #(.BOARD_SIZE(10), .MAX_PIECES(11)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tipo(tipo), .direcao(direcao),
        .orientacao(orientacao), .x1(x1), .y1(y1), .jogador(jogador),
        .vetor_leitura(vetor_leitura), .ready(ready),
        .conflitoMemoria_out(conflitoMemoria_out), .conflitoBorda_out(conflitoBorda_out),
        .conflito(conflito), .wrep1(wrep1), .wrep2(wrep2), .vetor(vetor),
        .read_addr(read_addr), .write_addr(write_addr)
    );

    // Per-player piece RAMs with one-cycle read latency
    logic [63:0] ram0 [32];
    logic [63:0] ram1 [32];
    logic        ram_jog = 1'b0;
    initial for (int i = 0; i < 32; i++) begin ram0[i] = '0; ram1[i] = '0; end
    always @(posedge clk) begin
        if (wrep1) ram0[write_addr] <= vetor;
        if (wrep2) ram1[write_addr] <= vetor;
        vetor_leitura <= ram_jog ? ram1[read_addr] : ram0[read_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int x; int y; } cell_t;
    typedef struct {
        bit borda; bit mem; bit wr; bit jog;
        logic [4:0] waddr; logic [63:0] word; int lat; int start;
    } exp_t;

    exp_t  sb[$];
    string to_q[$];
    cell_t cells0[$];
    cell_t cells1[$];
    int    mcnt [2];
    int    n_checks = 0;
    int    n_fail = 0;

    function automatic bit outside(input int v);
        return (v < 0) || (v >= 10);
    endfunction

    function automatic bit touch(input int ax, input int ay, input int bx, input int by);
`ifdef ADJACENCY_CHECK_EN
        return (ax - bx <= 1) && (bx - ax <= 1) && (ay - by <= 1) && (by - ay <= 1);
`else
        return (ax == bx) && (ay == by);
`endif
    endfunction

    function automatic void model_eval(input bit jog, input logic [2:0] t, input bit d,
                                       input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                                       output exp_t e, output int n, output int cx[5], output int cy[5]);
        bit    bad = 0, border, hit = 0;
        int    xi = int'(x), yi = int'(y), cnt;
        cell_t stored[$];
        logic [63:0] w;
        e.borda = 0; e.mem = 0; e.wr = 0; e.jog = jog; e.waddr = '0; e.word = '0;
        e.lat = 0; e.start = 0;
        n = 0;
        for (int k = 0; k < 5; k++) begin cx[k] = 0; cy[k] = 0; end
        if (t <= 3) begin
            n = 5 - int'(t);
            for (int k = 0; k < n; k++) begin
                cx[k] = d ? xi : xi + k;
                cy[k] = d ? yi + k : yi;
            end
        end else if (t == 4) begin
            n = 3; cx[0] = xi; cy[0] = yi;
            case (o[1:0])
                2'd0: begin cx[1] = xi + 1; cy[1] = yi + 1; cx[2] = xi + 2; cy[2] = yi; end
                2'd1: begin cx[1] = xi + 1; cy[1] = yi - 1; cx[2] = xi + 2; cy[2] = yi; end
                2'd2: begin cx[1] = xi + 1; cy[1] = yi + 1; cx[2] = xi; cy[2] = yi + 2; end
                default: begin cx[1] = xi - 1; cy[1] = yi + 1; cx[2] = xi; cy[2] = yi + 2; end
            endcase
        end else bad = 1;
        border = bad;
        for (int k = 0; k < n; k++) if (outside(cx[k]) || outside(cy[k])) border = 1;
        cnt = mcnt[jog];
        stored = jog ? cells1 : cells0;
        if (border) begin
            e.borda = 1; e.lat = 2;
        end else if (cnt == 11) begin
            e.mem = 1; e.lat = 2;
        end else begin
            foreach (stored[s])
                for (int k = 0; k < n; k++)
                    if (touch(stored[s].x, stored[s].y, cx[k], cy[k])) hit = 1;
            if (hit) e.mem = 1;
            else begin
                w = '0; w[63] = 1'b1; w[62:60] = t; w[59:57] = o; w[56] = d;
                for (int k = 0; k < n; k++) w[9*k +: 9] = {1'b1, 4'(cx[k]), 4'(cy[k])};
                e.wr = 1; e.waddr = 5'(cnt); e.word = w; e.lat = cnt + 3;
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: the only process that performs comparisons
    initial begin : monitor
        exp_t cur;
        bit have_cur = 0, rst_seen = 0, ready_d = 0, wj = 0;
        int strobes = 0;
        logic [4:0] wa = '0;
        logic [63:0] wv = '0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                if (!rst_seen) begin
                    rst_seen = 1;
                    #1;
                    check("rst_ready", 64'(ready), 64'd0);
                    check("rst_mem", 64'(conflitoMemoria_out), 64'd0);
                    check("rst_borda", 64'(conflitoBorda_out), 64'd0);
                    check("rst_conflito", 64'(conflito), 64'd0);
                    check("rst_wrep", 64'({wrep1, wrep2}), 64'd0);
                    check("rst_vetor", vetor, 64'd0);
                    check("rst_addr", 64'({read_addr, write_addr}), 64'd0);
                    sb.delete();
                    have_cur = 0; ready_d = 0; strobes = 0;
                end
            end else begin
                rst_seen = 0;
                while (to_q.size() > 0) begin
                    string s;
                    s = to_q.pop_front();
                    n_checks++; n_fail++;
                    $display("FAIL timeout_%s: expected event did not occur within cycle budget", s);
                end
                if (wrep1 || wrep2) begin
                    strobes++; wa = write_addr; wv = vetor; wj = wrep2;
                    check("single_strobe_line", 64'(wrep1 & wrep2), 64'd0);
                end
                if (ready && !ready_d) begin
                    if (sb.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_ready: actual=1 required=no pending request");
                    end else begin
                        cur = sb.pop_front(); have_cur = 1;
                        check("borda", 64'(conflitoBorda_out), 64'(cur.borda));
                        check("memoria", 64'(conflitoMemoria_out), 64'(cur.mem));
                        check("conflito", 64'(conflito), 64'(cur.borda | cur.mem));
                        check("strobe_count", 64'(strobes), 64'(cur.wr));
                        if (cur.wr) begin
                            check("write_addr", 64'(wa), 64'(cur.waddr));
                            check("write_data", wv, cur.word);
                            check("write_player", 64'(wj), 64'(cur.jog));
                        end
                        if (cur.lat > 0) check("latency", 64'(cyc - cur.start + 1), 64'(cur.lat));
                    end
                    strobes = 0;
                end else if (ready && have_cur) begin
                    check("hold_borda", 64'(conflitoBorda_out), 64'(cur.borda));
                    check("hold_memoria", 64'(conflitoMemoria_out), 64'(cur.mem));
                end
                ready_d = ready;
            end
        end
    end

    task automatic clear_model();
        mcnt[0] = 0; mcnt[1] = 0;
        cells0.delete(); cells1.delete();
    endtask

    task automatic issue(input bit jog, input logic [2:0] t, input bit d, input logic [2:0] o,
                         input logic [3:0] x, input logic [3:0] y);
        exp_t e; int n; int cx[5]; int cy[5];
        @(negedge clk);
        model_eval(jog, t, d, o, x, y, e, n, cx, cy);
        e.start = cyc + 1;
        jogador = jog; tipo = t; direcao = d; orientacao = o; x1 = x; y1 = y;
        ram_jog = jog; enable = 1'b1;
        sb.push_back(e);
        if (e.wr) begin
            mcnt[jog]++;
            for (int k = 0; k < n; k++)
                if (jog) cells1.push_back('{cx[k], cy[k]}); else cells0.push_back('{cx[k], cy[k]});
        end
    endtask

    task automatic do_req(input bit jog, input logic [2:0] t, input bit d, input logic [2:0] o,
                          input logic [3:0] x, input logic [3:0] y,
                          input int hold, input bit drop, input bit scramble);
        int tc;
        issue(jog, t, d, o, x, y);
        @(posedge clk);
        @(negedge clk);
        if (drop) enable = 1'b0;
        if (scramble) begin
            tipo = 3'($urandom_range(0, 7)); direcao = 1'($urandom);
            orientacao = 3'($urandom); x1 = 4'($urandom); y1 = 4'($urandom);
            jogador = 1'($urandom);
        end
        tc = 0;
        while (!ready && tc < 100) begin @(negedge clk); tc++; end
        if (!ready) to_q.push_back("ready");
        else if (!drop) repeat (hold) @(negedge clk);
        enable = 1'b0;
        tc = 0;
        while (ready && tc < 10) begin @(negedge clk); tc++; end
        if (ready) to_q.push_back("ready_release");
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : driver
        clear_model();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // directed sequence
        do_req(0, 3'd0, 0, 3'd0, 4'd7, 4'd0, 1, 0, 0);
        do_req(0, 3'd0, 0, 3'd0, 4'd1, 4'd1, 0, 0, 1);
        do_req(0, 3'd1, 0, 3'd0, 4'd1, 4'd1, 2, 0, 0);
        do_req(0, 3'd2, 0, 3'd0, 4'd3, 4'd3, 0, 0, 1);
        do_req(1, 3'd4, 0, 3'd3, 4'd0, 4'd0, 0, 0, 0);
        do_req(1, 3'd7, 0, 3'd0, 4'd2, 4'd2, 0, 1, 0);
        do_req(0, 3'd3, 0, 3'd0, 4'd0, 4'd8, 0, 1, 1);
        // reset while the three-entry scan is in progress
        issue(0, 3'd3, 0, 3'd0, 4'd8, 4'd8);
        @(posedge clk);
        pulse_reset();
        // after reset the counter restarts at zero
        for (int i = 0; i < 11; i++)
            do_req(1, 3'd3, 0, 3'd0, 4'((i % 3) * 4), 4'((i / 3) * 2), 0, 0, 0);
        do_req(1, 3'd3, 0, 3'd0, 4'd0, 4'd8, 1, 0, 0);
        // randomized traffic
        for (int i = 0; i < 160; i++) begin
            bit jg;
            logic [2:0] t;
            if (i == 80) pulse_reset();
            jg = ($urandom_range(0, 3) == 0);
            t  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            do_req(jg, t, 1'($urandom), 3'($urandom), 4'($urandom_range(0, 10)),
                   4'($urandom_range(0, 10)), $urandom_range(0, 2),
                   ($urandom_range(0, 4) == 0), 1'($urandom));
        end
        repeat (3) @(negedge clk);
        if (sb.size() != 0) to_q.push_back("pending_responses");
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
